// File: rtl/lut_neuron_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : lut_neuron_pipe
//  Purpose  : Runtime-programmable truth-table neuron with a streamed table
//             load and a 1- or 2-stage valid/ready inference pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
module lut_neuron_pipe #(
    parameter int IN_W    = 6,
    parameter int OUT_W   = 2,
    parameter int OUT_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             cfg_valid,
    input  logic [OUT_W-1:0] cfg_data,
    output logic             cfg_ready,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    input  logic             out_ready,
    output logic             table_ready,
    output logic             load_err
);

    localparam int              c_depth     = 1 << IN_W;
    localparam logic [IN_W-1:0] c_last_addr = {IN_W{1'b1}};
    localparam logic [IN_W-1:0] c_addr_one  = {{(IN_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_load  = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_run   = 2'd3;

    logic [1:0]      r_state;
    logic [IN_W-1:0] r_addr;
    logic            r_load_err;

    (* ram_style = "distributed" *)
    logic [OUT_W-1:0] r_table [c_depth];

    logic             r_a_valid;
    logic [IN_W-1:0]  r_a_data;

    logic             w_run;
    logic             w_cfg_fire;
    logic             w_in_fire;
    logic             w_a_adv;
    logic             w_pipe_empty;
    logic [OUT_W-1:0] w_lut_q;

    // A word offered alongside load_start is refused so the restart is clean.
    assign w_run       = (r_state == c_st_run);
    assign cfg_ready   = (r_state == c_st_load) && !load_start;
    assign w_cfg_fire  = cfg_valid && cfg_ready;
    assign w_in_fire   = in_valid && in_ready;
    assign table_ready = w_run;
    assign load_err    = r_load_err;
    assign w_lut_q     = r_table[r_a_data];

    always_ff @(posedge clk) begin
        if (w_cfg_fire) begin
            r_table[r_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_empty;
            r_addr     <= '0;
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= 1'b0;
            case (r_state)
                c_st_empty: begin
                    if (load_start) begin
                        r_state <= c_st_load;
                        r_addr  <= '0;
                    end
                end
                c_st_load: begin
                    if (load_start) begin
                        r_addr     <= '0;
                        r_load_err <= 1'b1;
                    end else if (w_cfg_fire) begin
                        r_addr <= r_addr + c_addr_one;
                        if (r_addr == c_last_addr) begin
                            r_state <= c_st_run;
                        end
                    end
                end
                c_st_run: begin
                    if (load_start) begin
                        r_state <= c_st_drain;
                    end
                end
                c_st_drain: begin
                    // Table writes wait until no sample can still read it.
                    if (w_pipe_empty) begin
                        r_state <= c_st_load;
                        r_addr  <= '0;
                    end
                end
                default: begin
                    r_state <= c_st_empty;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_valid <= 1'b0;
            r_a_data  <= '0;
        end else if (w_in_fire) begin
            r_a_valid <= 1'b1;
            r_a_data  <= in_data;
        end else if (w_a_adv) begin
            r_a_valid <= 1'b0;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic             r_b_valid;
            logic [OUT_W-1:0] r_b_data;
            logic             w_b_free;

            // Stage B can take a new entry when empty or emptying this cycle.
            assign w_b_free     = !r_b_valid || out_ready;
            assign w_a_adv      = r_a_valid && w_b_free;
            assign in_ready     = w_run && !load_start && (!r_a_valid || w_b_free);
            assign w_pipe_empty = !r_a_valid && !r_b_valid;
            assign out_valid    = r_b_valid;
            assign out_data     = r_b_data;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_b_valid <= 1'b0;
                    r_b_data  <= '0;
                end else if (w_b_free) begin
                    r_b_valid <= r_a_valid;
                    if (r_a_valid) begin
                        r_b_data <= w_lut_q;
                    end
                end
            end
        end else begin : g_out_comb
            assign w_a_adv      = r_a_valid && out_ready;
            assign in_ready     = w_run && !load_start && (!r_a_valid || out_ready);
            assign w_pipe_empty = !r_a_valid;
            assign out_valid    = r_a_valid;
            // Gated so the unreset table never shows on the output when idle.
            assign out_data     = r_a_valid ? w_lut_q : '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_lut_neuron_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lut_neuron_pipe
//  Purpose  : Self-checking bench for lut_neuron_pipe (registered and
//             combinational output variants).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lut_neuron_pipe;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-output instance, IN_W=6, OUT_W=2
    logic       rst, load_start, cfg_valid, cfg_ready;
    logic [1:0] cfg_data;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [5:0] in_data;
    logic [1:0] out_data;
    logic       table_ready, load_err;

    // Combinational-output instance, IN_W=4, OUT_W=3
    logic       rst2, load_start2, cfg_valid2, cfg_ready2;
    logic [2:0] cfg_data2;
    logic       in_valid2, in_ready2, out_valid2, out_ready2;
    logic [3:0] in_data2;
    logic [2:0] out_data2;
    logic       table_ready2, load_err2;

    int checks   = 0;
    int failures = 0;

    logic [1:0] model_tbl [64];
    logic [2:0] model2    [16];
    logic [1:0] exp_q [$];
    logic [2:0] exp2_q [$];

    lut_neuron_pipe #(.IN_W(6), .OUT_W(2), .OUT_REG(1)) u_dut (
        .clk(clk), .rst(rst), .load_start(load_start),
        .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .table_ready(table_ready), .load_err(load_err)
    );

    lut_neuron_pipe #(.IN_W(4), .OUT_W(3), .OUT_REG(0)) u_dut2 (
        .clk(clk), .rst(rst2), .load_start(load_start2),
        .cfg_valid(cfg_valid2), .cfg_data(cfg_data2), .cfg_ready(cfg_ready2),
        .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
        .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready2),
        .table_ready(table_ready2), .load_err(load_err2)
    );

    task automatic pulse_load();
        @(negedge clk);
        load_start = 1'b1;
        cfg_valid  = 1'b0;
        in_valid   = 1'b0;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // kind 0: entry k = k mod 4, kind 1: all 3, otherwise random
    task automatic load_words(input int n, input int kind);
        int k, guard;
        k = 0;
        guard = 0;
        while (k < n && guard < n + 200) begin
            @(negedge clk);
            cfg_valid = 1'b1;
            if (kind == 0)      cfg_data = k[1:0];
            else if (kind == 1) cfg_data = 2'd3;
            else                cfg_data = 2'($urandom_range(0, 3));
            #1;
            if (cfg_ready) begin
                model_tbl[k] = cfg_data;
                k++;
            end
            guard++;
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        checks++;
        if (k != n) begin
            failures++;
            $display("FAIL load_words accepted=%0d required=%0d", k, n);
        end
    endtask

    task automatic load_words2(input int n);
        int k, guard;
        k = 0;
        guard = 0;
        while (k < n && guard < n + 200) begin
            @(negedge clk);
            cfg_valid2 = 1'b1;
            cfg_data2  = 3'(15 - k);
            #1;
            if (cfg_ready2) begin
                model2[k] = cfg_data2;
                k++;
            end
            guard++;
        end
        @(negedge clk);
        cfg_valid2 = 1'b0;
        checks++;
        if (k != n) begin
            failures++;
            $display("FAIL load_words2 accepted=%0d required=%0d", k, n);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({cfg_ready, in_ready, out_valid, out_data, table_ready, load_err} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b required=0000000",
                     {cfg_ready, in_ready, out_valid, out_data, table_ready, load_err});
        end
        rst = 1'b0;
    endtask

    task automatic test_no_table();
        for (int w = 0; w < 6; w++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 6'($urandom_range(0, 63));
            #1;
            checks++;
            if ({in_ready, out_valid, table_ready} !== 3'b000) begin
                failures++;
                $display("FAIL no_table in_ready/out_valid/table_ready=%b required=000",
                         {in_ready, out_valid, table_ready});
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_basic_stream();
        logic [5:0] smp [3];
        logic [1:0] req [3];
        int acc_win [$];
        int out_win [$];
        logic [1:0] outs [$];
        int sent;
        smp[0] = 6'h05; smp[1] = 6'h2A; smp[2] = 6'h3F;
        req[0] = 2'd1;  req[1] = 2'd2;  req[2] = 2'd3;
        pulse_load();
        load_words(64, 0);
        sent = 0;
        for (int w = 0; w < 10; w++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (sent < 3);
            if (sent < 3) in_data = smp[sent];
            #1;
            if (out_valid && out_ready) begin
                out_win.push_back(w);
                outs.push_back(out_data);
            end
            if (in_valid && in_ready) begin
                acc_win.push_back(w);
                sent++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (acc_win.size() != 3 || out_win.size() != 3) begin
            failures++;
            $display("FAIL stream_count accepts=%0d outputs=%0d required=3/3",
                     acc_win.size(), out_win.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (acc_win[i] != i) begin
                    failures++;
                    $display("FAIL stream_accept_win[%0d] got=%0d required=%0d", i, acc_win[i], i);
                end
                checks++;
                if (outs[i] !== req[i]) begin
                    failures++;
                    $display("FAIL stream_data[%0d] got=%0d required=%0d", i, outs[i], req[i]);
                end
                checks++;
                if (out_win[i] != acc_win[0] + 2 + i) begin
                    failures++;
                    $display("FAIL stream_latency[%0d] got=%0d required=%0d",
                             i, out_win[i], acc_win[0] + 2 + i);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] smp [4];
        logic [1:0] exp;
        int sent, got, low_cnt;
        smp[0] = 6'h01; smp[1] = 6'h02; smp[2] = 6'h03; smp[3] = 6'h04;
        sent = 0; got = 0; low_cnt = 0;
        exp_q.delete();
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            out_ready = (w >= 5);
            in_valid  = (sent < 4);
            if (sent < 4) in_data = smp[sent];
            #1;
            if (out_valid && !out_ready) begin
                checks++;
                if (out_data !== 2'd1) begin
                    failures++;
                    $display("FAIL bp_hold got=%0d required=1", out_data);
                end
            end
            if (out_valid && out_ready) begin
                got++;
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
                checks++;
                if (out_data !== exp) begin
                    failures++;
                    $display("FAIL bp_order got=%0d required=%0d", out_data, exp);
                end
            end
            if (in_valid && !in_ready) low_cnt++;
            if (in_valid && in_ready) begin
                exp_q.push_back(model_tbl[in_data]);
                sent++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != 4) begin
            failures++;
            $display("FAIL bp_count got=%0d required=4", got);
        end
        checks++;
        if (low_cnt != 3) begin
            failures++;
            $display("FAIL bp_stall_cycles got=%0d required=3", low_cnt);
        end
    endtask

    task automatic test_load_restart();
        int errs, tr, got;
        pulse_load();
        load_words(10, 2);
        @(negedge clk);
        load_start = 1'b1;
        cfg_valid  = 1'b1;
        cfg_data   = 2'd0;
        #1;
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL restart_cfg_ready got=%b required=0", cfg_ready);
        end
        errs = 0; tr = 0;
        for (int w = 0; w < 6; w++) begin
            @(negedge clk);
            load_start = 1'b0;
            cfg_valid  = 1'b0;
            #1;
            if (load_err === 1'b1) errs++;
            if (table_ready !== 1'b0) tr++;
        end
        checks++;
        if (errs != 1) begin
            failures++;
            $display("FAIL load_err_cycles got=%0d required=1", errs);
        end
        checks++;
        if (tr != 0) begin
            failures++;
            $display("FAIL restart_table_ready high_cycles=%0d required=0", tr);
        end
        load_words(64, 1);
        got = 0;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (w < 6);
            in_data   = 6'($urandom_range(0, 63));
            #1;
            if (out_valid && out_ready) begin
                got++;
                checks++;
                if (out_data !== 2'd3) begin
                    failures++;
                    $display("FAIL all_ones_table got=%0d required=3", out_data);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (got != 6) begin
            failures++;
            $display("FAIL all_ones_count got=%0d required=6", got);
        end
    endtask

    task automatic test_random();
        int sent, got;
        logic [1:0] exp;
        pulse_load();
        load_words(64, 2);
        exp_q.delete();
        sent = 0; got = 0;
        for (int w = 0; w < 410; w++) begin
            @(negedge clk);
            in_valid  = (w < 400) && ($urandom_range(0, 9) < 7);
            in_data   = 6'($urandom_range(0, 63));
            out_ready = (w >= 400) || ($urandom_range(0, 9) < 6);
            #1;
            if (out_valid && out_ready) begin
                got++;
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
                checks++;
                if (out_data !== exp) begin
                    failures++;
                    $display("FAIL random_data got=%0d required=%0d", out_data, exp);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model_tbl[in_data]);
                sent++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != sent || exp_q.size() != 0) begin
            failures++;
            $display("FAIL random_count outputs=%0d required=%0d", got, sent);
        end
    endtask

    task automatic test_drain();
        int got, ir_bad, w;
        logic [1:0] exp;
        bit seen_load;
        exp_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 6'($urandom_range(0, 63));
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL drain_setup_in_ready got=%b required=1", in_ready);
            end
            if (in_valid && in_ready) exp_q.push_back(model_tbl[in_data]);
        end
        got = 0; ir_bad = 0; w = 0; seen_load = 1'b0;
        while (!seen_load && w < 20) begin
            @(negedge clk);
            load_start = (w == 0);
            in_valid   = 1'b1;
            in_data    = 6'($urandom_range(0, 63));
            #1;
            if (in_ready !== 1'b0) ir_bad++;
            if (out_valid && out_ready) begin
                got++;
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
                checks++;
                if (out_data !== exp) begin
                    failures++;
                    $display("FAIL drain_old_data got=%0d required=%0d", out_data, exp);
                end
            end
            if (cfg_ready === 1'b1) seen_load = 1'b1;
            w++;
        end
        load_start = 1'b0;
        in_valid   = 1'b0;
        checks++;
        if (!seen_load) begin
            failures++;
            $display("FAIL drain_to_load cfg_ready=0 after %0d cycles required=1", w);
        end
        checks++;
        if (ir_bad != 0) begin
            failures++;
            $display("FAIL drain_in_ready high_cycles=%0d required=0", ir_bad);
        end
        checks++;
        if (got != 2) begin
            failures++;
            $display("FAIL drain_completed got=%0d required=2", got);
        end
        load_words(64, 0);
        got = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = (i == 0);
            in_data  = 6'h07;
            #1;
            if (out_valid && out_ready) begin
                got++;
                checks++;
                if (out_data !== 2'd3) begin
                    failures++;
                    $display("FAIL reload_data got=%0d required=3", out_data);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (got != 1) begin
            failures++;
            $display("FAIL reload_count got=%0d required=1", got);
        end
    endtask

    task automatic test_comb_variant();
        int acc_w, out_w, sent, got;
        logic [2:0] exp;
        #1;
        checks++;
        if ({cfg_ready2, in_ready2, out_valid2, out_data2, table_ready2, load_err2} !== 8'b0) begin
            failures++;
            $display("FAIL v2_reset got=%b required=00000000",
                     {cfg_ready2, in_ready2, out_valid2, out_data2, table_ready2, load_err2});
        end
        @(negedge clk);
        rst2 = 1'b0;
        @(negedge clk);
        load_start2 = 1'b1;
        @(negedge clk);
        load_start2 = 1'b0;
        load_words2(16);
        acc_w = -1; out_w = -1;
        out_ready2 = 1'b1;
        for (int w = 0; w < 5; w++) begin
            @(negedge clk);
            in_valid2 = (acc_w < 0);
            in_data2  = 4'd2;
            #1;
            if (out_valid2 && out_ready2 && out_w < 0) begin
                out_w = w;
                checks++;
                if (out_data2 !== 3'd5) begin
                    failures++;
                    $display("FAIL v2_data got=%0d required=5", out_data2);
                end
            end
            if (in_valid2 && in_ready2) acc_w = w;
        end
        checks++;
        if (acc_w != 0 || out_w != 1) begin
            failures++;
            $display("FAIL v2_latency accept_win=%0d out_win=%0d required=0/1", acc_w, out_w);
        end
        exp2_q.delete();
        sent = 0; got = 0;
        for (int w = 0; w < 60; w++) begin
            @(negedge clk);
            in_valid2  = (w < 50) && ($urandom_range(0, 1) == 1);
            in_data2   = 4'($urandom_range(0, 15));
            out_ready2 = (w >= 50) || ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid2 && out_ready2) begin
                got++;
                exp = (exp2_q.size() != 0) ? exp2_q.pop_front() : 3'bxxx;
                checks++;
                if (out_data2 !== exp) begin
                    failures++;
                    $display("FAIL v2_random got=%0d required=%0d", out_data2, exp);
                end
            end
            if (in_valid2 && in_ready2) begin
                exp2_q.push_back(model2[in_data2]);
                sent++;
            end
        end
        in_valid2 = 1'b0;
        checks++;
        if (got != sent) begin
            failures++;
            $display("FAIL v2_random_count got=%0d required=%0d", got, sent);
        end
        @(negedge clk);
        load_start2 = 1'b1;
        @(negedge clk);
        load_start2 = 1'b0;
        load_words2(5);
        @(negedge clk);
        rst2 = 1'b1;
        #1;
        checks++;
        if ({cfg_ready2, in_ready2, out_valid2, out_data2, table_ready2, load_err2} !== 8'b0) begin
            failures++;
            $display("FAIL v2_midload_reset got=%b required=00000000",
                     {cfg_ready2, in_ready2, out_valid2, out_data2, table_ready2, load_err2});
        end
        @(negedge clk);
        rst2 = 1'b0;
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            cfg_valid2 = 1'b1;
            in_valid2  = 1'b1;
            #1;
            checks++;
            if ({cfg_ready2, in_ready2, table_ready2} !== 3'b000) begin
                failures++;
                $display("FAIL v2_empty_after_reset cfg/in/table_ready=%b required=000",
                         {cfg_ready2, in_ready2, table_ready2});
            end
        end
        cfg_valid2 = 1'b0;
        in_valid2  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        rst2 = 1'b1; load_start2 = 1'b0; cfg_valid2 = 1'b0; cfg_data2 = '0;
        in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
        test_reset();
        test_no_table();
        test_basic_stream();
        test_backpressure();
        test_load_restart();
        test_random();
        test_drain();
        test_comb_variant();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
